// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- registered, parametrised ALU with valid/ready handshakes.
//
// Purpose:
//   Accepts one operation per cycle from the issue logic and presents a
//   registered result plus status flags to the writeback stage. The output
//   register holds its contents while the consumer applies backpressure.
//
// Configuration macro:
//   ALU_PIPE_MUL_EN  When defined, opcode 9 (MUL) is implemented as an
//                    iterative shift-add multiplier with a BUSY state
//                    (latency WIDTH+1). When undefined, there is no multiplier
//                    and opcode 9 is reported as illegal with latency 1.
//
// Parameters:
//   WIDTH  operand/result width in bits (4..64)
//   SHW    low bits of b used as shift amount (derived, do not override)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand/opcode valid
//   in_ready   out  block can accept an operation this cycle
//   a, b       in   operands A and B
//   opcode     in   operation select (0..9 defined, 10..15 illegal)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  registered result
//   flags      out  {illegal, overflow, carry, negative, zero}
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  // Packs the flag vector; negative and zero always derive from the result.
  function automatic logic [4:0] pack_flags(
    input logic             ill,
    input logic             ovf,
    input logic             cy,
    input logic [WIDTH-1:0] r
  );
    return {ill, ovf, cy, r[WIDTH-1], (r == {WIDTH{1'b0}})};
  endfunction

  // Single-cycle datapath: returns {flags, result}. Any opcode not listed
  // (including MUL, which never reaches here when the multiplier exists)
  // yields result 0 with only illegal and zero set.
  function automatic logic [WIDTH+4:0] alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    logic             ill;
    logic             ovf;
    logic             cy;
    wide = {(WIDTH+1){1'b0}};
    r    = {WIDTH{1'b0}};
    sh   = y[SHW-1:0];
    ill  = 1'b0;
    ovf  = 1'b0;
    cy   = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        r    = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
        ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        r   = x - y;
        cy  = (x < y);
        ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_NOT: r = ~x;
      OP_XOR: r = x ^ y;
      OP_SHL: r = x << sh;
      OP_SHR: r = x >> sh;
      OP_SRA: r = $unsigned($signed(x) >>> sh);
      default: begin
        ill = 1'b1;
        r   = {WIDTH{1'b0}};
      end
    endcase
    return {pack_flags(ill, ovf, cy, r), r};
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic [WIDTH+4:0] eval;
  logic             accept;

  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               start_mul;
  logic               mul_done;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign start_mul = accept && (opcode == OP_MUL);
  // All WIDTH shift-add steps are complete; this edge loads the product.
  assign mul_done  = (state_q == BUSY) && (cnt_q == CNT_LAST);

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_mul ? BUSY : IDLE;
      BUSY:    state_d = mul_done ? IDLE : BUSY;
      default: state_d = IDLE;
    endcase
  end

  // Shift-add multiplier datapath: latch on start, one step per BUSY cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_mul) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = {CW{1'b0}};
    end else if ((state_q == BUSY) && !mul_done) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  // Output register next-state: load a new result, hand off, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    eval        = alu_eval(opcode, a, b);
`ifdef ALU_PIPE_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = acc_q[WIDTH-1:0];
      flags_d     = pack_flags(1'b0, 1'b0, |acc_q[2*WIDTH-1:WIDTH],
                               acc_q[WIDTH-1:0]);
    end else if (start_mul) begin
      // Any held result is handed off on this same edge (in_ready implies
      // out_ready), and nothing new is valid until the product loads.
      out_valid_d = 1'b0;
    end else if (accept) begin
`else
    if (accept) begin
`endif
      out_valid_d = 1'b1;
      result_d    = eval[WIDTH-1:0];
      flags_d     = eval[WIDTH+4:WIDTH];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 5'b00000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int     W    = 8;
  localparam int     SHW  = 3;
  localparam longint MOD  = 256;
  localparam longint MAXS = 127;
  localparam longint MINS = -128;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit           m_ov = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [4:0]   m_flg = '0;
  int           m_busy = 0;
  logic [W+4:0] m_mul = '0;
  bit           m_rst_seen = 1'b0;
  bit           m_after_rst = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Spec-level arithmetic reference: returns {illegal,overflow,carry,negative,zero,result}
  function automatic logic [W+4:0] ref_op(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint ua, ub, sa, sb, full, sres;
    logic [W-1:0] r;
    logic ill, ov, cy;
    int sh;
    ua = longint'(x);
    ub = longint'(y);
    sa = (ua > MAXS) ? ua - MOD : ua;
    sb = (ub > MAXS) ? ub - MOD : ub;
    sh = int'(y) % (1 << SHW);
    r = '0; ill = 1'b0; ov = 1'b0; cy = 1'b0;
    case (op)
      4'd0: begin
        full = ua + ub; r = W'(full % MOD); cy = (full >= MOD);
        sres = sa + sb; ov = (sres > MAXS) || (sres < MINS);
      end
      4'd1: begin
        full = ua - ub; r = W'((full + MOD) % MOD); cy = (ua < ub);
        sres = sa - sb; ov = (sres > MAXS) || (sres < MINS);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = ~x;
      4'd5: r = x ^ y;
      4'd6: r = W'((ua << sh) % MOD);
      4'd7: r = W'(ua >> sh);
      4'd8: r = W'((((sa >>> sh) % MOD) + MOD) % MOD);
      4'd9: begin
        if (MUL_EN) begin
          full = ua * ub; r = W'(full % MOD); cy = (full >= MOD);
        end else begin
          ill = 1'b1; r = '0;
        end
      end
      default: begin ill = 1'b1; r = '0; end
    endcase
    return {ill, ov, cy, r[W-1], (r == '0), r};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit rdy;
    if (rst) begin
      m_ov = 1'b0; m_res = '0; m_flg = '0; m_busy = 0;
      m_rst_seen = 1'b1; m_after_rst = 1'b1;
    end else begin
      rdy = (m_busy == 0) && (!m_ov || out_ready);
      m_after_rst = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov = 1'b1;
          {m_flg, m_res} = m_mul;
        end
      end else begin
        if (m_ov && out_ready) m_ov = 1'b0;
        if (in_valid && rdy) begin
          if (MUL_EN && opcode == 4'd9) begin
            m_busy = W + 1;
            m_mul  = ref_op(opcode, a, b);
            m_ov   = 1'b0;
          end else begin
            m_ov = 1'b1;
            {m_flg, m_res} = ref_op(opcode, a, b);
          end
        end
      end
    end
  endtask

  // Compare process: DUT versus model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_rst_seen) begin
      check("in_ready", in_ready, (m_busy == 0) && (!m_ov || out_ready));
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("result", result, m_res);
        check("flags", flags, m_flg);
      end else if (m_after_rst) begin
        check("rst_result", result, 64'd0);
        check("rst_flags", flags, 64'd0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [3:0] op, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic ordy, input logic r);
    in_valid = v; opcode = op; a = x; b = y; out_ready = ordy; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals [4];
    edge_vals[0] = 8'h00; edge_vals[1] = 8'hFF; edge_vals[2] = 8'h7F; edge_vals[3] = 8'h80;

    // Hand-computed expectations pinning the reference model
    check("pin_add_7f_01", ref_op(4'd0, 8'h7F, 8'h01), {5'b01010, 8'h80});
    check("pin_add_ff_01", ref_op(4'd0, 8'hFF, 8'h01), {5'b00101, 8'h00});
    check("pin_sub_5_5",   ref_op(4'd1, 8'h05, 8'h05), {5'b00001, 8'h00});
    check("pin_sub_3_5",   ref_op(4'd1, 8'h03, 8'h05), {5'b00110, 8'hFE});
    check("pin_not_0f",    ref_op(4'd4, 8'h0F, 8'h00), {5'b00010, 8'hF0});
    check("pin_sra_90_2",  ref_op(4'd8, 8'h90, 8'h02), {5'b00010, 8'hE4});
    check("pin_shl_81_9",  ref_op(4'd6, 8'h81, 8'h09), {5'b00000, 8'h02});
    check("pin_op12",      ref_op(4'd12, 8'h33, 8'h44), {5'b10001, 8'h00});
    check("pin_mul_10_10", ref_op(4'd9, 8'h10, 8'h10),
          MUL_EN ? {5'b00101, 8'h00} : {5'b10001, 8'h00});

    // Reset
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Directed operations, back to back with out_ready=1
    cyc(1'b1, 4'd0, 8'h7F, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 8'h05, 8'h05, 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 8'h03, 8'h05, 1'b1, 1'b0);
    cyc(1'b1, 4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0);
    cyc(1'b1, 4'd3, 8'hF0, 8'h0C, 1'b1, 1'b0);
    cyc(1'b1, 4'd5, 8'hAA, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 4'd4, 8'h0F, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 4'd8, 8'h90, 8'h02, 1'b1, 1'b0);
    cyc(1'b1, 4'd6, 8'h81, 8'h09, 1'b1, 1'b0);
    cyc(1'b1, 4'd7, 8'h81, 8'h08, 1'b1, 1'b0);
    cyc(1'b1, 4'd15, 8'h12, 8'h34, 1'b1, 1'b0);

    // Backpressure: result held, new valid ignored, then handoff + accept
    cyc(1'b1, 4'd0, 8'h10, 8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 8'hAA, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 8'hAA, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // MUL 0x10*0x10 with inputs pressed during BUSY
    cyc(1'b1, 4'd9, 8'h10, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < W + 3; i++) cyc(1'b1, 4'd0, 8'h01, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 4'd9, 8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < W + 3; i++) cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset on cycle 3 of a MUL, then illegal opcode 12
    cyc(1'b1, 4'd9, 8'hFF, 8'hFF, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 4'd12, 8'h33, 8'h44, 1'b1, 1'b0);
    for (int i = 0; i < W + 4; i++) cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset while a result is held under backpressure
    cyc(1'b1, 4'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ra, rb,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
    end
    for (int i = 0; i < W + 3; i++) cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
